axi4_lite_cmd_queue: RTL
========================

# axi4_lite_cmd_queue

Buffered command front-end that sits directly upstream of the AXI4-Lite manager. It accepts read and write commands from the controlling logic and queues them in a command FIFO. It issues the commands to the manager strictly in order, using credit-based flow control, and returns each completion through a response FIFO. Misaligned commands are rejected locally with SLVERR, without reaching the bus, and ordering is still preserved.

## Interface
Parameters:
- DATA_WIDTH, 32, width of write and read data.
- ADDR_WIDTH, 32, width of the byte address.
- CMD_DEPTH, 4, command FIFO entries; a power of 2, at least 2.
- RSP_DEPTH, 4, response FIFO entries; a power of 2, at least 2. This is also the credit limit.

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- areset  in  1  reset; asynchronous and active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  equals !cmd_full.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- mgr_req_valid  out  1  request to the manager.
- mgr_req_ready  in  1  manager accepts the request.
- mgr_req_write  out  1  forwarded cmd_write.
- mgr_req_addr  out  ADDR_WIDTH  forwarded cmd_addr.
- mgr_req_wdata  out  DATA_WIDTH  forwarded cmd_wdata.
- mgr_rsp_valid  in  1  manager completion; one-cycle pulse, no back-pressure.
- mgr_rsp_rdata  in  DATA_WIDTH  read data; 0 for writes.
- mgr_rsp_resp  in  2  RRESP/BRESP.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_WIDTH  response data.
- rsp_resp  out  2  response code.
- outstanding  out  $clog2(RSP_DEPTH)+1  requests issued to the manager and not yet completed.
- err_sticky  out  1  set by an unexpected mgr_rsp_valid.

## Operation
- **Command FIFO.** Push on cmd_valid && cmd_ready. The FIFO is first-word-fall-through.
- **Response FIFO.** Push on each mgr_rsp_valid or local error, pop on rsp_valid && rsp_ready. rsp_valid = !rsp_empty.
- **Issue FSM states:**
  - IDLE: command FIFO empty.
  - ISSUE: head entry aligned, mgr_req_valid asserted.
  - DRAIN: head misaligned, waiting for outstanding == 0.
  - LOCAL: push {rdata 0, resp 2'b10} into the response FIFO, pop the head, return to IDLE.
- **Alignment.** The head is aligned when addr[1:0] == 0.
- **Credit gate.** mgr_req_valid = head present && aligned && (outstanding + rsp_count < RSP_DEPTH), so the response FIFO can never overflow.
- **mgr_req_\* fields** are driven directly from the head entry. They stay stable while mgr_req_valid && !mgr_req_ready.
- **outstanding** increments on each request handshake and decrements on each mgr_rsp_valid. Both events in the same cycle leave it unchanged.
- **Unexpected response.** mgr_rsp_valid while outstanding == 0 is dropped and sets err_sticky. err_sticky is cleared only by areset.
- **Response passthrough.** mgr_rsp_resp is passed through unmodified, including 2'b11 (DECERR).
- **Full/empty boundaries:**
  - A push and pop in the same cycle on a non-full, non-empty FIFO leaves its count unchanged.
  - No push is possible when full; the command FIFO blocks through cmd_ready, and the response FIFO is protected by the credit gate.
  - Pointers wrap modulo depth; an extra MSB distinguishes full from empty.
- **Reset.** areset at any time empties both FIFOs, discards in-flight credit, and returns the FSM to IDLE. Completions from the manager that arrive after release count as unexpected.

## Timing
- Reset values: cmd_ready 0 while areset is asserted and 1 from the first edge after release; mgr_req_valid 0; rsp_valid 0; outstanding 0; err_sticky 0; all data outputs 0.
- Command to request: a command pushed at edge N has mgr_req_valid high after edge N+1, when the FIFO was empty and credit is available.
- Completion to response: mgr_rsp_valid at edge N gives rsp_valid after edge N+1.
- Local error: a misaligned head with outstanding == 0 has its SLVERR response visible 2 cycles after it reaches the head.
- Throughput: one command per cycle when the manager keeps mgr_req_ready high.

## Structure
- The shared package axi4_lite_pkg holds:
  - resp_e enum: OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11.
  - cmd_t struct: write, addr, wdata.
  - rsp_t struct: rdata, resp.
  - The issue state enum.
- Sub-module axi4_lite_sync_fifo, parameterised by WIDTH and DEPTH, is instantiated twice: once for commands, once for responses.

## Test plan
- **Single read.** Read 0x04; manager returns 0xCECE_BBBB/OKAY 3 cycles later. Required: rsp_rdata 0xCECE_BBBB, rsp_resp 0, outstanding back to 0.
- **Credit gate.** RSP_DEPTH 4, rsp_ready held 0, 6 reads issued with manager responses returned immediately. Required: exactly 4 request handshakes, then mgr_req_valid stays 0. Raising rsp_ready releases the remaining 2.
- **Misaligned ordering.** Write 0x08 (manager delays its response 5 cycles), then read 0x0A. Required: the write OKAY is delivered before the SLVERR, and 0x0A never appears on mgr_req_addr.
- **Full FIFO.** CMD_DEPTH 4, mgr_req_ready 0, 5 commands offered. Required: cmd_ready drops after the 4th push and the 5th is held until the first issue.
- **Spurious response.** mgr_rsp_valid pulsed with outstanding 0. Required: err_sticky 1, no response pushed.
- **Reset mid-operation.** Assert areset with 2 commands queued and 1 outstanding. Required: all outputs at reset values, FIFO counts 0; a late completion sets err_sticky.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: response codes, queued command/response payloads and
// the issue FSM state encoding.
package axi4_lite_pkg;

  // Stored payload widths; bus ports narrower than these are zero-extended on entry.
  localparam int AXIL_ADDR_WIDTH = 32;
  localparam int AXIL_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef struct packed {
    logic                       write;
    logic [AXIL_ADDR_WIDTH-1:0] addr;
    logic [AXIL_DATA_WIDTH-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [AXIL_DATA_WIDTH-1:0] rdata;
    resp_e                      resp;
  } rsp_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_DRAIN = 2'b10,
    ST_LOCAL = 2'b11
  } issue_state_e;

  function automatic logic is_aligned(input logic [1:0] addr_lsbs);
    return addr_lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/axi4_lite_sync_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry an extra wrap bit so
// full and empty are distinguishable.
module axi4_lite_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/axi4_lite_cmd_queue.sv
// In-order command front-end for the AXI4-Lite manager: queued commands,
// credit-gated issue, local SLVERR for misaligned commands, queued responses.
module axi4_lite_cmd_queue
  import axi4_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CMD_DEPTH  = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [ADDR_WIDTH-1:0]        cmd_addr,
  input  logic [DATA_WIDTH-1:0]        cmd_wdata,
  output logic                         mgr_req_valid,
  input  logic                         mgr_req_ready,
  output logic                         mgr_req_write,
  output logic [ADDR_WIDTH-1:0]        mgr_req_addr,
  output logic [DATA_WIDTH-1:0]        mgr_req_wdata,
  input  logic                         mgr_rsp_valid,
  input  logic [DATA_WIDTH-1:0]        mgr_rsp_rdata,
  input  logic [1:0]                   mgr_rsp_resp,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic [1:0]                   rsp_resp,
  output logic [$clog2(RSP_DEPTH):0]   outstanding,
  output logic                         err_sticky
);

  localparam int CCW = $clog2(CMD_DEPTH) + 1;
  localparam int RCW = $clog2(RSP_DEPTH) + 1;

  cmd_t             cmd_in;
  cmd_t             cmd_head;
  rsp_t             rsp_in;
  rsp_t             rsp_head;
  logic             cmd_empty;
  logic             cmd_full;
  logic             rsp_empty;
  logic [CCW-1:0]   cmd_count;
  logic [RCW-1:0]   rsp_count;
  logic             cmd_push;
  logic             cmd_pop;
  logic             rsp_push;
  logic             rsp_pop;

  issue_state_e     state_reg;
  logic             ready_en_reg;
  logic [RCW-1:0]   outstanding_reg;
  logic             err_sticky_reg;
  logic             rsp_pipe_valid_reg;
  rsp_t             rsp_pipe_reg;

  logic             head_aligned;
  logic [RCW:0]     credit_used;
  logic             credit_ok;
  logic             local_ok;
  logic             req_hs;
  logic             rsp_expected;
  logic             local_push;

  // cmd_ready stays low during reset and rises on the first edge after release
  assign cmd_full  = (cmd_count == CCW'(CMD_DEPTH));
  assign cmd_ready = ready_en_reg && !cmd_full;
  assign cmd_push  = cmd_valid && cmd_ready;
  assign cmd_in    = '{write: cmd_write,
                       addr:  AXIL_ADDR_WIDTH'(cmd_addr),
                       wdata: AXIL_DATA_WIDTH'(cmd_wdata)};

  axi4_lite_sync_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .aclk      (aclk),
    .areset    (areset),
    .push      (cmd_push),
    .push_data (cmd_in),
    .pop       (cmd_pop),
    .pop_data  (cmd_head),
    .empty     (cmd_empty),
    .count     (cmd_count)
  );

  // A response still in the input register holds a slot as well
  assign credit_used  = (RCW+1)'(outstanding_reg) + (RCW+1)'(rsp_count)
                      + (RCW+1)'(rsp_pipe_valid_reg);
  assign credit_ok    = credit_used < (RCW+1)'(RSP_DEPTH);
  assign local_ok     = (outstanding_reg == '0) && credit_ok;
  assign head_aligned = is_aligned(cmd_head.addr[1:0]);

  assign mgr_req_valid = (state_reg == ST_ISSUE) && !cmd_empty && head_aligned && credit_ok;
  assign req_hs        = mgr_req_valid && mgr_req_ready;
  assign mgr_req_write = mgr_req_valid && cmd_head.write;
  assign mgr_req_addr  = mgr_req_valid ? ADDR_WIDTH'(cmd_head.addr)  : '0;
  assign mgr_req_wdata = mgr_req_valid ? DATA_WIDTH'(cmd_head.wdata) : '0;

  assign local_push   = (state_reg == ST_LOCAL);
  assign cmd_pop      = req_hs || local_push;
  assign rsp_expected = mgr_rsp_valid && (outstanding_reg != '0);

  // LOCAL is only entered with nothing outstanding, so it never collides
  // with a registered manager completion
  assign rsp_push = rsp_pipe_valid_reg || local_push;
  assign rsp_in   = local_push ? '{rdata: '0, resp: SLVERR} : rsp_pipe_reg;
  assign rsp_pop  = rsp_valid && rsp_ready;

  axi4_lite_sync_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .aclk      (aclk),
    .areset    (areset),
    .push      (rsp_push),
    .push_data (rsp_in),
    .pop       (rsp_pop),
    .pop_data  (rsp_head),
    .empty     (rsp_empty),
    .count     (rsp_count)
  );

  assign rsp_valid   = !rsp_empty;
  assign rsp_rdata   = rsp_empty ? '0 : DATA_WIDTH'(rsp_head.rdata);
  assign rsp_resp    = rsp_empty ? 2'b00 : rsp_head.resp;
  assign outstanding = outstanding_reg;
  assign err_sticky  = err_sticky_reg;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ready_en_reg       <= 1'b0;
      outstanding_reg    <= '0;
      err_sticky_reg     <= 1'b0;
      rsp_pipe_valid_reg <= 1'b0;
      rsp_pipe_reg       <= '0;
    end else begin
      ready_en_reg <= 1'b1;
      if (req_hs && !rsp_expected)
        outstanding_reg <= outstanding_reg + RCW'(1);
      else if (!req_hs && rsp_expected)
        outstanding_reg <= outstanding_reg - RCW'(1);
      if (mgr_rsp_valid && !rsp_expected)
        err_sticky_reg <= 1'b1;
      rsp_pipe_valid_reg <= rsp_expected;
      if (rsp_expected)
        rsp_pipe_reg <= '{rdata: AXIL_DATA_WIDTH'(mgr_rsp_rdata), resp: resp_e'(mgr_rsp_resp)};
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_reg <= ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE, ST_ISSUE: begin
          if (cmd_empty)         state_reg <= ST_IDLE;
          else if (head_aligned) state_reg <= ST_ISSUE;
          else if (local_ok)     state_reg <= ST_LOCAL;
          else                   state_reg <= ST_DRAIN;
        end
        ST_DRAIN: if (local_ok) state_reg <= ST_LOCAL;
        ST_LOCAL: state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
